// File: rtl/mips_mc_ctrl_if.sv
// Control-to-datapath bundle for the multi-cycle MIPS controller.
// The master side is the controller; the slave side is the datapath and any observer.
interface mips_mc_ctrl_if #(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               pc_wr;
    logic               ir_wr;
    logic               rf_wr;
    logic               dm_wr;
    logic [1:0]         reg_dst;
    logic [1:0]         wd_sel;
    logic               alu_src;
    logic [1:0]         ext_op;
    logic [1:0]         alu_op;
    logic [1:0]         npc_sel;
    logic [STATE_W-1:0] state;
    logic               retire;
    logic               illegal;
    logic [CNT_W-1:0]   instr_cnt;

    modport master (
        input  op, funct, zero,
        output pc_wr, ir_wr, rf_wr, dm_wr, reg_dst, wd_sel, alu_src, ext_op,
               alu_op, npc_sel, state, retire, illegal, instr_cnt
    );

    modport slave (
        output op, funct, zero,
        input  pc_wr, ir_wr, rf_wr, dm_wr, reg_dst, wd_sel, alu_src, ext_op,
               alu_op, npc_sel, state, retire, illegal, instr_cnt
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Moore-style multi-cycle MIPS control unit: steps IF/ID/EXE/MEM/WB and drives
// datapath enables and selects from the current state plus the latched op/funct.
module mips_mc_ctrl #(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    mips_mc_ctrl_if.master    bus
);
    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EXE_R   = 4'd2,
        S_EXE_I   = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_R    = 4'd7,
        S_WB_I    = 4'd8,
        S_WB_LD   = 4'd9,
        S_BR      = 4'd10
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] instr_cnt_r;
    logic             pc_wr_s, ir_wr_s, rf_wr_s, dm_wr_s, alu_src_s, retire_s, illegal_s;
    logic [1:0]       reg_dst_s, wd_sel_s, ext_op_s, alu_op_s, npc_sel_s;

    // Next-state and output decode; reset forces IF and silences every output.
    always_comb begin
        state_s   = S_IF;
        pc_wr_s   = 1'b0;
        ir_wr_s   = 1'b0;
        rf_wr_s   = 1'b0;
        dm_wr_s   = 1'b0;
        alu_src_s = 1'b0;
        retire_s  = 1'b0;
        illegal_s = 1'b0;
        reg_dst_s = 2'd0;
        wd_sel_s  = 2'd0;
        ext_op_s  = 2'd0;
        alu_op_s  = 2'd0;
        npc_sel_s = 2'd0;
        if (rst) begin
            state_s = S_IF;
        end else begin
            case (state_r)
                S_IF: begin
                    ir_wr_s = 1'b1;
                    pc_wr_s = 1'b1;
                    state_s = S_ID;
                end
                S_ID: begin
                    case (bus.op)
                        6'h00: begin
                            case (bus.funct)
                                6'h21, 6'h23: state_s = S_EXE_R;
                                6'h08: begin
                                    pc_wr_s   = 1'b1;
                                    npc_sel_s = 2'd3;
                                    retire_s  = 1'b1;
                                end
                                default: illegal_s = 1'b1;
                            endcase
                        end
                        6'h0D, 6'h0F: state_s = S_EXE_I;
                        6'h23, 6'h2B: state_s = S_MEM_ADR;
                        6'h04:        state_s = S_BR;
                        6'h02, 6'h03: begin
                            pc_wr_s   = 1'b1;
                            npc_sel_s = 2'd2;
                            retire_s  = 1'b1;
                            // jal links PC+4 into $31 in the same cycle as the jump
                            if (bus.op == 6'h03) begin
                                rf_wr_s   = 1'b1;
                                reg_dst_s = 2'd2;
                                wd_sel_s  = 2'd2;
                            end else begin
                                rf_wr_s   = 1'b0;
                            end
                        end
                        default: illegal_s = 1'b1;
                    endcase
                end
                S_EXE_R, S_WB_R: begin
                    alu_op_s = (bus.funct == 6'h23) ? 2'd1 : 2'd0;
                    if (state_r == S_WB_R) begin
                        rf_wr_s   = 1'b1;
                        reg_dst_s = 2'd1;
                        retire_s  = 1'b1;
                    end else begin
                        state_s   = S_WB_R;
                    end
                end
                S_EXE_I, S_WB_I: begin
                    alu_src_s = 1'b1;
                    alu_op_s  = 2'd2;
                    ext_op_s  = (bus.op == 6'h0F) ? 2'd2 : 2'd0;
                    if (state_r == S_WB_I) begin
                        rf_wr_s  = 1'b1;
                        retire_s = 1'b1;
                    end else begin
                        state_s  = S_WB_I;
                    end
                end
                S_MEM_ADR: begin
                    alu_src_s = 1'b1;
                    ext_op_s  = 2'd1;
                    state_s   = (bus.op == 6'h2B) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: state_s = S_WB_LD;
                S_MEM_WR: begin
                    dm_wr_s  = 1'b1;
                    retire_s = 1'b1;
                end
                S_WB_LD: begin
                    rf_wr_s  = 1'b1;
                    wd_sel_s = 2'd1;
                    retire_s = 1'b1;
                end
                S_BR: begin
                    alu_op_s  = 2'd1;
                    ext_op_s  = 2'd1;
                    npc_sel_s = 2'd1;
                    pc_wr_s   = bus.zero;
                    retire_s  = 1'b1;
                end
                default: state_s = S_IF;
            endcase
        end
    end

    // State register and retired-instruction counter (wraps silently).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IF;
            instr_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (retire_s) begin
                instr_cnt_r <= instr_cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.pc_wr     = pc_wr_s;
    assign bus.ir_wr     = ir_wr_s;
    assign bus.rf_wr     = rf_wr_s;
    assign bus.dm_wr     = dm_wr_s;
    assign bus.reg_dst   = reg_dst_s;
    assign bus.wd_sel    = wd_sel_s;
    assign bus.alu_src   = alu_src_s;
    assign bus.ext_op    = ext_op_s;
    assign bus.alu_op    = alu_op_s;
    assign bus.npc_sel   = npc_sel_s;
    assign bus.state     = STATE_W'(state_r);
    assign bus.retire    = retire_s;
    assign bus.illegal   = illegal_s;
    assign bus.instr_cnt = instr_cnt_r;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: directed table of instruction walks, hand-written
// reset/wrap sequences, and random instructions against an instruction-level model.
module tb_mips_mc_ctrl;
    localparam int CNT_W   = 32;
    localparam int STATE_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_mc_ctrl_if #(.CNT_W(CNT_W), .STATE_W(STATE_W)) bus ();
    mips_mc_ctrl #(.CNT_W(CNT_W), .STATE_W(STATE_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [3:0] st;
        logic       pc_wr, ir_wr, rf_wr, dm_wr;
        logic [1:0] reg_dst, wd_sel;
        logic       alu_src;
        logic [1:0] ext_op, alu_op, npc_sel;
        logic       retire, illegal;
    } obs_t;

    typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_ILL} kind_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        int          lat;
        logic [19:0] sts;   // state at step i lives in sts[4*i +: 4]
        logic [4:0]  pc_m, rf_m, dm_m, ill_m;
    } tv_t;

    int               vecs = 0;
    int               errs = 0;
    logic [CNT_W-1:0] exp_cnt;
    tv_t              tv [13];
    logic [5:0]       rops [10];
    logic [5:0]       rfun [10];

    function automatic obs_t observe();
        obs_t o;
        o = '{bus.state, bus.pc_wr, bus.ir_wr, bus.rf_wr, bus.dm_wr, bus.reg_dst,
              bus.wd_sel, bus.alu_src, bus.ext_op, bus.alu_op, bus.npc_sel,
              bus.retire, bus.illegal};
        return o;
    endfunction

    function automatic kind_t kind_of(input logic [5:0] op, input logic [5:0] funct);
        case (op)
            6'h00:   return (funct == 6'h21 || funct == 6'h23) ? K_R :
                            (funct == 6'h08) ? K_JR : K_ILL;
            6'h0D, 6'h0F: return K_I;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic int lat_of(input kind_t k);
        case (k)
            K_J, K_JAL, K_JR, K_ILL: return 2;
            K_BEQ:                   return 3;
            K_LW:                    return 5;
            default:                 return 4;
        endcase
    endfunction

    // Expected outputs for cycle 'step' of an instruction of kind k.
    function automatic obs_t model(input kind_t k, input int step, input logic [5:0] op,
                                   input logic [5:0] funct, input logic zero);
        obs_t e = '0;
        if (step == 0) begin
            e.pc_wr = 1'b1; e.ir_wr = 1'b1;
        end else if (step == 1) begin
            e.st = 4'd1;
            if (k == K_J || k == K_JAL) begin e.pc_wr = 1'b1; e.npc_sel = 2'd2; e.retire = 1'b1; end
            if (k == K_JAL) begin e.rf_wr = 1'b1; e.reg_dst = 2'd2; e.wd_sel = 2'd2; end
            if (k == K_JR)  begin e.pc_wr = 1'b1; e.npc_sel = 2'd3; e.retire = 1'b1; end
            if (k == K_ILL) e.illegal = 1'b1;
        end else begin
            case (k)
                K_R: begin
                    e.alu_op = (funct == 6'h23) ? 2'd1 : 2'd0;
                    e.st     = (step == 2) ? 4'd2 : 4'd7;
                    if (step == 3) begin e.rf_wr = 1'b1; e.reg_dst = 2'd1; e.retire = 1'b1; end
                end
                K_I: begin
                    e.alu_src = 1'b1; e.alu_op = 2'd2;
                    e.ext_op  = (op == 6'h0F) ? 2'd2 : 2'd0;
                    e.st      = (step == 2) ? 4'd3 : 4'd8;
                    if (step == 3) begin e.rf_wr = 1'b1; e.retire = 1'b1; end
                end
                K_LW, K_SW: begin
                    if (step == 2) begin e.st = 4'd4; e.alu_src = 1'b1; e.ext_op = 2'd1; end
                    else if (k == K_SW) begin e.st = 4'd6; e.dm_wr = 1'b1; e.retire = 1'b1; end
                    else if (step == 3) e.st = 4'd5;
                    else begin e.st = 4'd9; e.rf_wr = 1'b1; e.wd_sel = 2'd1; e.retire = 1'b1; end
                end
                K_BEQ: begin
                    e.st = 4'd10; e.alu_op = 2'd1; e.ext_op = 2'd1; e.npc_sel = 2'd1;
                    e.pc_wr = zero; e.retire = 1'b1;
                end
                default: e.st = 4'hF;
            endcase
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One instruction, every cycle compared against the model; ends at the next IF.
    task automatic run_model(input logic [5:0] op, input logic [5:0] funct);
        kind_t k = kind_of(op, funct);
        obs_t  e;
        for (int s = 0; s < lat_of(k); s++) begin
            bus.op = op; bus.funct = funct; bus.zero = 1'($urandom);
            #1;
            e = model(k, s, op, funct, bus.zero);
            check("model_step", 64'(observe()), 64'(e));
            if (e.retire) exp_cnt = exp_cnt + CNT_W'(1);
            next_cycle();
        end
        check("model_end_state", 64'(bus.state), 64'd0);
        check("model_cnt", 64'(bus.instr_cnt), 64'(exp_cnt));
    endtask

    initial begin
        tv[0]  = '{6'h00, 6'h21, 1'b0, 4, {4'd0, 4'd7, 4'd2, 4'd1, 4'd0}, 5'b00001, 5'b01000, 5'b00000, 5'b00000};
        tv[1]  = '{6'h00, 6'h23, 1'b1, 4, {4'd0, 4'd7, 4'd2, 4'd1, 4'd0}, 5'b00001, 5'b01000, 5'b00000, 5'b00000};
        tv[2]  = '{6'h23, 6'h15, 1'b0, 5, {4'd9, 4'd5, 4'd4, 4'd1, 4'd0}, 5'b00001, 5'b10000, 5'b00000, 5'b00000};
        tv[3]  = '{6'h2B, 6'h00, 1'b0, 4, {4'd0, 4'd6, 4'd4, 4'd1, 4'd0}, 5'b00001, 5'b00000, 5'b01000, 5'b00000};
        tv[4]  = '{6'h04, 6'h00, 1'b1, 3, {4'd0, 4'd0, 4'd10, 4'd1, 4'd0}, 5'b00101, 5'b00000, 5'b00000, 5'b00000};
        tv[5]  = '{6'h04, 6'h00, 1'b0, 3, {4'd0, 4'd0, 4'd10, 4'd1, 4'd0}, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
        tv[6]  = '{6'h03, 6'h00, 1'b0, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 5'b00011, 5'b00010, 5'b00000, 5'b00000};
        tv[7]  = '{6'h02, 6'h00, 1'b0, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 5'b00011, 5'b00000, 5'b00000, 5'b00000};
        tv[8]  = '{6'h00, 6'h08, 1'b0, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 5'b00011, 5'b00000, 5'b00000, 5'b00000};
        tv[9]  = '{6'h0D, 6'h00, 1'b0, 4, {4'd0, 4'd8, 4'd3, 4'd1, 4'd0}, 5'b00001, 5'b01000, 5'b00000, 5'b00000};
        tv[10] = '{6'h0F, 6'h00, 1'b0, 4, {4'd0, 4'd8, 4'd3, 4'd1, 4'd0}, 5'b00001, 5'b01000, 5'b00000, 5'b00000};
        tv[11] = '{6'h3F, 6'h21, 1'b0, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 5'b00001, 5'b00000, 5'b00000, 5'b00010};
        tv[12] = '{6'h00, 6'h2A, 1'b0, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 5'b00001, 5'b00000, 5'b00000, 5'b00010};
        rops = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
        rfun = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

        // Reset held two cycles: IF would normally drive pc_wr/ir_wr, reset silences them.
        rst = 1'b1; bus.op = 6'h00; bus.funct = 6'h21; bus.zero = 1'b0;
        next_cycle();
        next_cycle();
        check("reset_outputs", 64'(observe()), 64'd0);
        check("reset_cnt", 64'(bus.instr_cnt), 64'd0);
        rst = 1'b0;
        exp_cnt = '0;

        // Directed table: state walk and key enables per cycle.
        for (int i = 0; i < 13; i++) begin
            for (int s = 0; s < tv[i].lat; s++) begin
                bus.op = tv[i].op; bus.funct = tv[i].funct; bus.zero = tv[i].zero;
                #1;
                check($sformatf("table%0d_step%0d", i, s),
                      64'({bus.state, bus.pc_wr, bus.rf_wr, bus.dm_wr, bus.illegal}),
                      64'({tv[i].sts[4*s +: 4], tv[i].pc_m[s], tv[i].rf_m[s],
                           tv[i].dm_m[s], tv[i].ill_m[s]}));
                next_cycle();
            end
            if (tv[i].ill_m == 5'b00000) exp_cnt = exp_cnt + CNT_W'(1);
            check($sformatf("table%0d_end", i), 64'({bus.state, bus.instr_cnt}),
                  64'({4'd0, exp_cnt}));
        end

        // Reset during MEM_WR of sw: write suppressed, counter cleared.
        bus.op = 6'h2B; bus.funct = 6'h00;
        for (int s = 0; s < 3; s++) next_cycle();
        check("sw_in_memwr", 64'(bus.state), 64'd6);
        rst = 1'b1;
        #1;
        check("rst_memwr_dm_wr", 64'({bus.dm_wr, bus.retire}), 64'd0);
        next_cycle();
        rst = 1'b0;
        exp_cnt = '0;
        check("rst_memwr_after", 64'({bus.state, bus.instr_cnt}), 64'd0);

        // Counter at all-ones wraps to zero on the next retire.
        force dut.instr_cnt_r = {CNT_W{1'b1}};
        #1;
        release dut.instr_cnt_r;
        check("cnt_preset", 64'(bus.instr_cnt), 64'({CNT_W{1'b1}}));
        exp_cnt = {CNT_W{1'b1}};
        run_model(6'h00, 6'h21);
        check("cnt_wrap", 64'(bus.instr_cnt), 64'd0);

        // Random instruction mix, including arbitrary op/funct encodings.
        for (int n = 0; n < 150; n++) begin
            int idx = int'($urandom_range(0, 11));
            if (idx < 10) run_model(rops[idx], rfun[idx]);
            else          run_model(6'($urandom), 6'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multi-cycle control unit for the MIPS datapath. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives all datapath write enables and mux selects from the current state and the latched opcode/funct. It also counts retired instructions for the bench. It replaces the single-cycle combinational decoder in the `mips` top so that IM, DM, RF and ALU are each used once per state.

Parameters:
CNT_W, 32, width of retired-instruction counter
STATE_W, 4, width of state encoding output

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
op  input  6  IR[31:26], valid from ID onward (IR latched in IF)
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, valid in BR state
pc_wr  output  1  PC write enable
ir_wr  output  1  IR write enable
rf_wr  output  1  register file write enable
dm_wr  output  1  data memory write enable
reg_dst  output  2  0 rt, 1 rd, 2 $31
wd_sel  output  2  RF write data: 0 ALU, 1 DM, 2 PC+4
alu_src  output  1  ALU B: 0 rt, 1 extended imm
ext_op  output  2  0 zero-ext, 1 sign-ext, 2 imm<<16
alu_op  output  2  0 add, 1 sub, 2 or
npc_sel  output  2  0 PC+4, 1 branch target, 2 j target, 3 rs (jr)
state  output  STATE_W  current state, for debug
retire  output  1  one-cycle pulse in the last state of each instruction
illegal  output  1  one-cycle pulse on undecodable instruction
instr_cnt  output  CNT_W  retired instruction count

Behaviour:
- States: IF=0, ID=1, EXE_R=2, EXE_I=3, MEM_ADR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_I=8, WB_LD=9, BR=10.
- Supported: addu(0/21h), subu(0/23h), jr(0/08h), ori(0Dh), lui(0Fh), lw(23h), sw(2Bh), beq(04h), j(02h), jal(03h). Values are hex op/funct.
- Reset: state<=IF, instr_cnt<=0. While rst=1, all outputs are 0: the enables and retire/illegal are gated by rst and the selects are forced to 0.
- IF: ir_wr=1, pc_wr=1, npc_sel=0. Always goes to ID.
- ID: decode.
  - R-addu/subu -> EXE_R.
  - ori/lui -> EXE_I.
  - lw/sw -> MEM_ADR.
  - beq -> BR.
  - j: pc_wr=1, npc_sel=2, retire=1; -> IF.
  - jal: j behaviour plus rf_wr=1, reg_dst=2, wd_sel=2.
  - jr: pc_wr=1, npc_sel=3, retire=1; -> IF.
  - Anything else: illegal=1, no writes, no retire; -> IF. The PC has already advanced, so the instruction is skipped.
- EXE_R: alu_src=0, alu_op=0 (addu) or 1 (subu). -> WB_R.
- EXE_I: alu_src=1, alu_op=2, ext_op=0 (ori) or 2 (lui; ALU computes 0|ext). -> WB_I.
- MEM_ADR: alu_src=1, ext_op=1, alu_op=0. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: no enables. -> WB_LD.
- MEM_WR: dm_wr=1, retire=1. -> IF.
- WB_R: rf_wr=1, reg_dst=1, wd_sel=0, retire=1; alu select values held from EXE_R. -> IF.
- WB_I: rf_wr=1, reg_dst=0, wd_sel=0, retire=1; EXE_I selects held. -> IF.
- WB_LD: rf_wr=1, reg_dst=0, wd_sel=1, retire=1. -> IF.
- BR: alu_src=0, alu_op=1, ext_op=1, npc_sel=1, pc_wr=zero, retire=1. -> IF.
- Latency in cycles:
  - j/jal/jr: 2
  - beq: 3
  - addu/subu/ori/lui/sw: 4
  - lw: 5
- Outputs are pure functions of state, op and funct (plus zero in BR). op/funct must be stable from ID until retire, which the IR guarantees because ir_wr is asserted only in IF.
- instr_cnt increments on a clock edge where retire=1. It wraps from 2^CNT_W-1 to 0 silently. Illegal instructions are not counted.
- Reset mid-instruction: the next edge forces IF, and any pending write is suppressed in the reset cycle.
- Undefined state encodings (11-15) go to IF on the next edge with no outputs asserted.

Test Plan:
- Reset held 2 cycles then released, op=0 funct=21h: state sequence 0,1,2,7,0; rf_wr=1 only in state 7 with reg_dst=1; instr_cnt=1 after that edge.
- op=23h (lw): states 0,1,4,5,9; alu_src=1 and ext_op=1 in state 4; rf_wr with wd_sel=1 in state 9; dm_wr never high.
- op=04h, zero=1, then repeat with zero=0: BR asserts pc_wr=1 with npc_sel=1 only in the zero=1 case; both retire in 3 cycles.
- op=03h (jal): 2-cycle instruction; ID asserts pc_wr=1, npc_sel=2, rf_wr=1, reg_dst=2, wd_sel=2. op=0 funct=08h gives npc_sel=3 and rf_wr=0.
- op=3Fh: illegal pulses in ID, no rf_wr/dm_wr, instr_cnt unchanged, next state IF.
- Assert rst during MEM_WR of a sw: dm_wr=0 that cycle, state=0 next, instr_cnt=0. Separately, preset the counter to all-ones via 2^32-1 retires (force): the next retire gives 0.
